// File: rtl/jtag_tap_pkg.sv
// Shared TAP state encoding, instruction codes and the 1149.1 next-state function.
package jtag_tap_pkg;

  typedef logic [3:0] tap_state_t;

  localparam tap_state_t TLR    = 4'hF;
  localparam tap_state_t RTI    = 4'hC;
  localparam tap_state_t SEL_DR = 4'h7;
  localparam tap_state_t CAP_DR = 4'h6;
  localparam tap_state_t SH_DR  = 4'h2;
  localparam tap_state_t EX1_DR = 4'h1;
  localparam tap_state_t PA_DR  = 4'h3;
  localparam tap_state_t EX2_DR = 4'h0;
  localparam tap_state_t UPD_DR = 4'h5;
  localparam tap_state_t SEL_IR = 4'h4;
  localparam tap_state_t CAP_IR = 4'hE;
  localparam tap_state_t SH_IR  = 4'hA;
  localparam tap_state_t EX1_IR = 4'h9;
  localparam tap_state_t PA_IR  = 4'hB;
  localparam tap_state_t EX2_IR = 4'h8;
  localparam tap_state_t UPD_IR = 4'hD;

  localparam int unsigned INSTR_IDCODE = 32'h1;
  localparam int unsigned INSTR_USER   = 32'h2;
  localparam logic [31:0] INSTR_BYPASS = 32'hFFFF_FFFF;

  function automatic tap_state_t next_tap_state(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TLR:     n = tms ? TLR    : RTI;
      RTI:     n = tms ? SEL_DR : RTI;
      SEL_DR:  n = tms ? SEL_IR : CAP_DR;
      CAP_DR:  n = tms ? EX1_DR : SH_DR;
      SH_DR:   n = tms ? EX1_DR : SH_DR;
      EX1_DR:  n = tms ? UPD_DR : PA_DR;
      PA_DR:   n = tms ? EX2_DR : PA_DR;
      EX2_DR:  n = tms ? UPD_DR : SH_DR;
      UPD_DR:  n = tms ? SEL_DR : RTI;
      SEL_IR:  n = tms ? TLR    : CAP_IR;
      CAP_IR:  n = tms ? EX1_IR : SH_IR;
      SH_IR:   n = tms ? EX1_IR : SH_IR;
      EX1_IR:  n = tms ? UPD_IR : PA_IR;
      PA_IR:   n = tms ? EX2_IR : PA_IR;
      EX2_IR:  n = tms ? UPD_IR : SH_IR;
      UPD_IR:  n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_responder_if.sv
// JTAG pin bundle between the vector player (master) and the TAP responder (slave).
interface jtag_tap_responder_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tck, output tms, output tdi, input tdo, input tdo_oe);
  modport slave  (input tck, input tms, input tdi, output tdo, output tdo_oe);
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; advances only on the synchronized tck rise strobe.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tck_rise,
  input  logic       tms,
  output tap_state_t state_q,
  output tap_state_t state_next_c
);

  tap_state_t state_d;

  always_comb begin
    state_next_c = next_tap_state(state_q, tms);
    state_d      = state_q;
    if (tck_rise) state_d = state_next_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TLR;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/jtag_tap_responder.sv
// Loopback JTAG target: oversampled pins, IR/BYPASS/IDCODE/USER registers, tdo on tck fall.
// Optional JTAG_TAP_EDGE_CNT_EN adds a 16-bit detected-tck-rise counter output.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1DE10001,
  parameter int unsigned USER_DR_WIDTH = 32,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  jtag_tap_responder_if.slave      jtag,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_value,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_update
`ifdef JTAG_TAP_EDGE_CNT_EN
  , output logic [15:0]            tck_rise_count
`endif
);

  logic [SYNC_STAGES-1:0]   tck_sync_q, tck_sync_d;
  logic [SYNC_STAGES-1:0]   tms_sync_q, tms_sync_d;
  logic [SYNC_STAGES-1:0]   tdi_sync_q, tdi_sync_d;
  logic                     tck_prev_q, tck_prev_d;
  logic [IR_WIDTH-1:0]      ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0]      ir_value_q, ir_value_d;
  logic                     bypass_q, bypass_d;
  logic [31:0]              idcode_sr_q, idcode_sr_d;
  logic [USER_DR_WIDTH-1:0] user_sr_q, user_sr_d;
  logic [USER_DR_WIDTH-1:0] user_dr_out_q, user_dr_out_d;
  logic                     user_update_q, user_update_d;
  logic                     tdo_q, tdo_d;
  logic                     tdo_oe_q, tdo_oe_d;

  logic       tck_s_c, tms_s_c, tdi_s_c;
  logic       tck_rise_c, tck_fall_c;
  logic       sel_idcode_c, sel_user_c, dr_lsb_c;
  tap_state_t state_c, state_next_c;

  jtag_tap_fsm u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .tck_rise     (tck_rise_c),
    .tms          (tms_s_c),
    .state_q      (state_c),
    .state_next_c (state_next_c)
  );

  // tms/tdi are read from the same stage as tck so they stay aligned with the edge.
  assign tck_s_c      = tck_sync_q[SYNC_STAGES-1];
  assign tms_s_c      = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s_c      = tdi_sync_q[SYNC_STAGES-1];
  assign tck_rise_c   = tck_s_c & ~tck_prev_q;
  assign tck_fall_c   = ~tck_s_c & tck_prev_q;
  assign sel_idcode_c = (ir_value_q == IR_WIDTH'(INSTR_IDCODE));
  assign sel_user_c   = (ir_value_q == IR_WIDTH'(INSTR_USER));
  assign dr_lsb_c     = sel_idcode_c ? idcode_sr_q[0] : (sel_user_c ? user_sr_q[0] : bypass_q);

  always_comb begin
    tck_sync_d    = {tck_sync_q[SYNC_STAGES-2:0], jtag.tck};
    tms_sync_d    = {tms_sync_q[SYNC_STAGES-2:0], jtag.tms};
    tdi_sync_d    = {tdi_sync_q[SYNC_STAGES-2:0], jtag.tdi};
    tck_prev_d    = tck_s_c;
    ir_sr_d       = ir_sr_q;
    ir_value_d    = ir_value_q;
    bypass_d      = bypass_q;
    idcode_sr_d   = idcode_sr_q;
    user_sr_d     = user_sr_q;
    user_dr_out_d = user_dr_out_q;
    user_update_d = 1'b0;
    tdo_d         = tdo_q;
    tdo_oe_d      = tdo_oe_q;

    if (tck_rise_c) begin
      case (state_c)
        CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
        SH_IR:  ir_sr_d = {tdi_s_c, ir_sr_q[IR_WIDTH-1:1]};
        UPD_IR: ir_value_d = ir_sr_q;
        CAP_DR: begin
          if (sel_idcode_c)    idcode_sr_d = IDCODE_VALUE;
          else if (sel_user_c) user_sr_d   = user_dr_in;
          else                 bypass_d    = 1'b0;
        end
        SH_DR: begin
          if (sel_idcode_c)    idcode_sr_d = {tdi_s_c, idcode_sr_q[31:1]};
          else if (sel_user_c) user_sr_d   = {tdi_s_c, user_sr_q[USER_DR_WIDTH-1:1]};
          else                 bypass_d    = tdi_s_c;
        end
        UPD_DR: begin
          if (sel_user_c) begin
            user_dr_out_d = user_sr_q;
            user_update_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (state_next_c == TLR) ir_value_d = IR_WIDTH'(INSTR_IDCODE);
    end

    // tdo changes on the falling edge so the initiator samples it stable on the next rise.
    if (tck_fall_c) begin
      if (state_c == SH_IR) begin
        tdo_d    = ir_sr_q[0];
        tdo_oe_d = 1'b1;
      end else if (state_c == SH_DR) begin
        tdo_d    = dr_lsb_c;
        tdo_oe_d = 1'b1;
      end else begin
        tdo_oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync_q    <= '0;
      tms_sync_q    <= '0;
      tdi_sync_q    <= '0;
      tck_prev_q    <= 1'b0;
      ir_sr_q       <= '0;
      ir_value_q    <= IR_WIDTH'(INSTR_IDCODE);
      bypass_q      <= 1'b0;
      idcode_sr_q   <= '0;
      user_sr_q     <= '0;
      user_dr_out_q <= '0;
      user_update_q <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
    end else begin
      tck_sync_q    <= tck_sync_d;
      tms_sync_q    <= tms_sync_d;
      tdi_sync_q    <= tdi_sync_d;
      tck_prev_q    <= tck_prev_d;
      ir_sr_q       <= ir_sr_d;
      ir_value_q    <= ir_value_d;
      bypass_q      <= bypass_d;
      idcode_sr_q   <= idcode_sr_d;
      user_sr_q     <= user_sr_d;
      user_dr_out_q <= user_dr_out_d;
      user_update_q <= user_update_d;
      tdo_q         <= tdo_d;
      tdo_oe_q      <= tdo_oe_d;
    end
  end

`ifdef JTAG_TAP_EDGE_CNT_EN
  logic [15:0] rise_cnt_q, rise_cnt_d;

  // Cleared only on a transition into TLR; rises while parked in TLR still count.
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    if (tck_rise_c) begin
      if (state_next_c == TLR && state_c != TLR) rise_cnt_d = 16'd0;
      else                                       rise_cnt_d = rise_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rise_cnt_q <= 16'd0;
    else        rise_cnt_q <= rise_cnt_d;
  end

  assign tck_rise_count = rise_cnt_q;
`endif

  assign tap_state   = state_c;
  assign ir_value    = ir_value_q;
  assign user_dr_out = user_dr_out_q;
  assign user_update = user_update_q;
  assign jtag.tdo    = tdo_q;
  assign jtag.tdo_oe = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: expected values queued on stimulus, popped on observation.
module tb_jtag_tap_responder;

  localparam int unsigned IR_W   = 4;
  localparam int unsigned UDR_W  = 32;
  localparam int unsigned SYNC_N = 2;
  localparam int unsigned HOLD   = SYNC_N + 4;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [3:0]       tap_state;
  logic [IR_W-1:0]  ir_value;
  logic [UDR_W-1:0] user_dr_in;
  logic [UDR_W-1:0] user_dr_out;
  logic             user_update;
`ifdef JTAG_TAP_EDGE_CNT_EN
  logic [15:0]      tck_rise_count;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   upd_cnt  = 0;
  int   upd_base;
  logic [63:0] dout;

  jtag_tap_responder_if jif ();

  jtag_tap_responder #(
    .IR_WIDTH      (IR_W),
    .IDCODE_VALUE  (32'h1DE10001),
    .USER_DR_WIDTH (UDR_W),
    .SYNC_STAGES   (SYNC_N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jtag        (jif),
    .tap_state   (tap_state),
    .ir_value    (ir_value),
    .user_dr_in  (user_dr_in),
    .user_dr_out (user_dr_out),
    .user_update (user_update)
`ifdef JTAG_TAP_EDGE_CNT_EN
    , .tck_rise_count (tck_rise_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (user_update === 1'b1) upd_cnt++;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tck_cycle(input logic tms_v, input logic tdi_v);
    @(negedge clk);
    jif.tms = tms_v;
    jif.tdi = tdi_v;
    repeat (2) @(negedge clk);
    jif.tck = 1'b1;
    repeat (HOLD) @(negedge clk);
    jif.tck = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  // Sample tdo before each rise; tms goes high on the final bit to leave Shift.
  task automatic scan(input int n, input logic [63:0] din, output logic [63:0] dout_o);
    dout_o = '0;
    for (int i = 0; i < n; i++) begin
      dout_o[i] = jif.tdo;
      tck_cycle(i == n - 1, din[i]);
    end
  endtask

  task automatic goto_shift_dr();
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic exit_to_rti();
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic shift_ir(input logic [IR_W-1:0] code, output logic [63:0] dout_o);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    scan(IR_W, 64'(code), dout_o);
    exit_to_rti();
  endtask

  initial begin
    rst_n      = 1'b0;
    jif.tck    = 1'b0;
    jif.tms    = 1'b0;
    jif.tdi    = 1'b0;
    user_dr_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push("rst_tap_state", 64'hF);       check(64'(tap_state));
    push("rst_ir_value", 64'h1);        check(64'(ir_value));
    push("rst_tdo", 64'h0);             check(64'(jif.tdo));
    push("rst_tdo_oe", 64'h0);          check(64'(jif.tdo_oe));
    push("rst_user_dr_out", 64'h0);     check(64'(user_dr_out));
    push("rst_user_update", 64'h0);     check(64'(user_update));

    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    push("rti_tap_state", 64'hC);       check(64'(tap_state));
    push("rti_ir_value", 64'h1);        check(64'(ir_value));
    push("rti_tdo_oe", 64'h0);          check(64'(jif.tdo_oe));
`ifdef JTAG_TAP_EDGE_CNT_EN
    push("rise_count_rti", 64'd6);      check(64'(tck_rise_count));
`endif

    upd_base = upd_cnt;
    goto_shift_dr();
    push("shdr_tdo_oe", 64'h1);         check(64'(jif.tdo_oe));
    push("idcode_scan", 64'h1DE10001);
    scan(32, 64'h0, dout);              check(dout);
    exit_to_rti();
    push("idcode_exit_state", 64'hC);   check(64'(tap_state));
    push("idcode_no_update", 64'd0);    check(64'(upd_cnt - upd_base));

    push("capir_bits_bypass", 64'h1);
    shift_ir(4'hF, dout);               check(dout);
    push("ir_bypass", 64'hF);           check(64'(ir_value));

    push("bypass_scan", 64'h14A);
    goto_shift_dr();
    scan(9, 64'h0A5, dout);             check(dout);
    exit_to_rti();

    push("capir_bits_user", 64'h1);
    shift_ir(4'h2, dout);               check(dout);
    push("ir_user", 64'h2);             check(64'(ir_value));
    user_dr_in = 32'hCAFEF00D;
    upd_base   = upd_cnt;
    push("user_capture", 64'hCAFEF00D);
    goto_shift_dr();
    scan(32, 64'h12345678, dout);       check(dout);
    exit_to_rti();
    push("user_dr_out", 64'h12345678);  check(64'(user_dr_out));
    push("user_update_clks", 64'd1);    check(64'(upd_cnt - upd_base));
    push("user_exit_state", 64'hC);     check(64'(tap_state));

    goto_shift_dr();
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push("async_rst_tap_state", 64'hF); check(64'(tap_state));
    push("async_rst_ir_value", 64'h1);  check(64'(ir_value));
    push("async_rst_tdo", 64'h0);       check(64'(jif.tdo));
    push("async_rst_tdo_oe", 64'h0);    check(64'(jif.tdo_oe));
    push("async_rst_user_out", 64'h0);  check(64'(user_dr_out));
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    jif.tms = 1'b0;
    jif.tck = 1'b1;
    repeat (2) @(negedge clk);
    jif.tck = 1'b0;
    $display("NOTE protocol violation: tck high for 2 clk (< SYNC_STAGES+2), results not checked");
    repeat (HOLD) @(negedge clk);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push("final_tap_state", 64'hF);     check(64'(tap_state));
`ifdef JTAG_TAP_EDGE_CNT_EN
    push("rise_count_rst", 64'd0);      check(64'(tck_rise_count));
`endif

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
